// File: rtl/psum_requant_out_if.sv
// Stream bundle between the PE row chain, the requant stage and its consumer.
// The slave side is the requant block; the master side drives psums and ready.
interface psum_requant_out_if #(
    parameter int BW_IN = 19
);
    logic [BW_IN-1:0] iPsum;
    logic             iValid;
    logic             iSof;
    logic [15:0]      iBias;
    logic [3:0]       iShift;
    logic [7:0]       oData;
    logic             oValid;
    logic             iReady;
    logic             oOvf;

    modport slave (
        input  iPsum, iValid, iSof, iBias, iShift, iReady,
        output oData, oValid, oOvf
    );

    modport master (
        output iPsum, iValid, iSof, iBias, iShift, iReady,
        input  oData, oValid, oOvf
    );
endinterface

// File: rtl/psum_requant_out.sv
// Drops row warm-up columns, then bias + ReLU + rounded shift + int8 saturation.
// Results queue in a small FIFO behind a valid/ready handshake.
module psum_requant_out #(
    parameter int BW_IN      = 19,
    parameter int K          = 5,
    parameter int IMG_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                iCLK,
    input  logic                iRSTn,
    psum_requant_out_if.slave   bus
);
    localparam int SW = BW_IN + 2;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [CW-1:0]        r_col;
    logic [CW-1:0]        w_idx;
    logic                 w_keep;
    logic signed [SW-1:0] r_sum;
    logic signed [SW-1:0] w_half;
    logic signed [SW-1:0] w_r;
    logic [3:0]           r_shift;
    logic                 r_v1;
    logic                 r_v2;
    logic [7:0]           r_q;
    logic [7:0]           w_q;
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr;
    logic [AW-1:0]        r_rd;
    logic [AW-1:0]        w_rd_nx;
    logic [AW:0]          r_cnt;
    logic [7:0]           r_data;
    logic                 r_ovf;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_push;
    logic                 w_drop;

    assign w_idx  = bus.iSof ? '0 : r_col;
    assign w_keep = bus.iValid && (w_idx >= CW'(K - 1));

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_col <= '0;
        end else if (bus.iValid) begin
            r_col <= (w_idx == CW'(IMG_W - 1)) ? '0 : w_idx + CW'(1);
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_sum   <= '0;
            r_shift <= '0;
            r_v1    <= 1'b0;
        end else begin
            r_v1 <= w_keep;
            if (w_keep) begin
                r_sum   <= {{(SW-BW_IN){bus.iPsum[BW_IN-1]}}, bus.iPsum}
                         + {{(SW-16){bus.iBias[15]}}, bus.iBias};
                r_shift <= bus.iShift;
            end
        end
    end

    // Adding half an LSB before the arithmetic shift rounds half up.
    always_comb begin
        w_half = '0;
        if (r_shift != 4'd0) begin
            w_half = SW'(1) << (r_shift - 4'd1);
        end
        w_r = (r_sum + w_half) >>> r_shift;
        w_q = w_r[7:0];
        if (w_r[SW-1]) begin
            w_q = 8'd0;
        end else if (|w_r[SW-2:7]) begin
            w_q = 8'd127;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_q  <= '0;
            r_v2 <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_q <= w_q;
            end
        end
    end

    assign w_full  = (r_cnt == (AW+1)'(FIFO_DEPTH));
    assign w_pop   = (r_cnt != '0) && bus.iReady;
    assign w_push  = r_v2 && (!w_full || w_pop);
    assign w_drop  = r_v2 && w_full && !w_pop;
    assign w_rd_nx = r_rd + AW'(1);

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
            r_data <= '0;
            r_ovf  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= r_q;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= w_rd_nx;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            // Head register: holds the last popped value once the FIFO drains.
            if (w_pop) begin
                if (r_cnt > (AW+1)'(1)) begin
                    r_data <= r_mem[w_rd_nx];
                end else if (w_push) begin
                    r_data <= r_q;
                end
            end else if (w_push && (r_cnt == '0)) begin
                r_data <= r_q;
            end
        end
    end

    assign bus.oData  = r_data;
    assign bus.oValid = (r_cnt != '0);
    assign bus.oOvf   = r_ovf;
endmodule

// File: tb/tb_psum_requant_out.sv
// Randomized and directed bench for psum_requant_out.
// A queue-based reference model predicts oValid, oData and oOvf every cycle.
module tb_psum_requant_out;
    localparam int K     = 5;
    localparam int IMG_W = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    psum_requant_out_if #(.BW_IN(19)) bus ();

    psum_requant_out dut (
        .iCLK  (clk),
        .iRSTn (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int due;
        int val;
    } pend_t;

    pend_t pq[$];
    int    fq[$];
    int    col;
    int    last;
    int    edge_n;
    int    n_vec;
    int    n_err;
    int    n_hs;
    bit    ovf;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    // Rounded division by 2^s with floor semantics, then ReLU and clamp.
    function automatic int ref_q(input int p, input int b, input int s);
        int sum;
        int d;
        int num;
        int r;
        sum = p + b;
        if (s == 0) begin
            r = sum;
        end else begin
            d   = 1 << s;
            num = sum + d / 2;
            r   = num / d;
            if (num < 0 && (num % d) != 0) r = r - 1;
        end
        if (r < 0) r = 0;
        if (r > 127) r = 127;
        return r;
    endfunction

    task automatic model_clear();
        pq.delete();
        fq.delete();
        col  = 0;
        last = 0;
        ovf  = 1'b0;
    endtask

    task automatic model_edge();
        bit    pop;
        bit    full;
        bit    have;
        int    v;
        int    idx;
        pend_t e;
        edge_n++;
        if (!rst_n) begin
            model_clear();
            return;
        end
        have = 1'b0;
        v    = 0;
        pop  = (fq.size() != 0) && bus.iReady;
        full = (fq.size() == DEPTH);
        if (pq.size() != 0 && pq[0].due == edge_n) begin
            e    = pq.pop_front();
            v    = e.val;
            have = 1'b1;
        end
        if (pop) last = fq.pop_front();
        if (have) begin
            if (full && !pop) ovf = 1'b1;
            else fq.push_back(v);
        end
        if (bus.iValid) begin
            idx = bus.iSof ? 0 : col;
            col = (idx == IMG_W - 1) ? 0 : idx + 1;
            if (idx >= K - 1) begin
                e.due = edge_n + 2;
                e.val = ref_q(int'($signed(bus.iPsum)),
                              int'($signed(bus.iBias)),
                              int'(bus.iShift));
                pq.push_back(e);
            end
        end
    endtask

    task automatic step();
        bit hs;
        int exp_d;
        hs = bus.oValid && bus.iReady && rst_n;
        @(posedge clk);
        if (hs) n_hs++;
        model_edge();
        #1;
        exp_d = (fq.size() != 0) ? fq[0] : last;
        chk("oValid", bus.oValid, fq.size() != 0);
        chk("oData", bus.oData, exp_d);
        chk("oOvf", bus.oOvf, ovf);
    endtask

    task automatic drive(input bit v, input bit s, input int p, input int b,
                         input int sh, input bit rdy);
        bus.iValid = v;
        bus.iSof   = s;
        bus.iPsum  = p[18:0];
        bus.iBias  = b[15:0];
        bus.iShift = sh[3:0];
        bus.iReady = rdy;
        step();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, rdy);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        idle(2, 1);
        #2 rst_n = 1'b1;
    endtask

    int arith_p[4];

    initial begin
        n_vec  = 0;
        n_err  = 0;
        n_hs   = 0;
        edge_n = 0;
        model_clear();
        bus.iValid = 0;
        bus.iSof   = 0;
        bus.iPsum  = '0;
        bus.iBias  = '0;
        bus.iShift = '0;
        bus.iReady = 1;

        // Reset held with valid input
        for (int i = 0; i < 4; i++) drive(1, 0, 50, 0, 0, 1);
        #2 rst_n = 1'b1;
        idle(5, 1);
        chk("reset_nopush", n_hs, 0);

        // Warm-up columns
        n_hs = 0;
        for (int i = 0; i < 8; i++) drive(1, i == 0, 100, 0, 0, 1);
        idle(6, 1);
        chk("warm_cnt", n_hs, 4);

        // Arithmetic corners
        arith_p = '{131071, 26, -50, 9};
        for (int i = 0; i < 4; i++) drive(1, i == 0, 0, -6, 2, 1);
        for (int i = 0; i < 4; i++) drive(1, 0, arith_p[i], -6, 2, 1);
        idle(6, 1);

        // Column wrap, then iSof restarting mid-row
        do_reset();
        n_hs = 0;
        for (int i = 0; i < 40; i++) drive(1, 0, i * 3, 0, 0, 1);
        idle(6, 1);
        chk("wrap_cnt", n_hs, 32);
        n_hs = 0;
        for (int i = 0; i < 16; i++) drive(1, i == 0 || i == 10, i, 0, 0, 1);
        idle(6, 1);
        chk("sof_cnt", n_hs, 8);

        // Back-pressure overflow
        do_reset();
        for (int i = 0; i < 10; i++) drive(1, i == 0, 10 * i, 0, 0, 0);
        idle(3, 0);
        chk("ovf_set", bus.oOvf, 1);
        n_hs = 0;
        idle(8, 1);
        chk("drain_cnt", n_hs, 4);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 8; i++) drive(1, i == 0, 7 * i, 3, 0, 0);
        idle(3, 0);
        for (int i = 0; i < 20; i++) drive(1, 0, 5 * i, 1, 1, 1);
        idle(8, 1);
        chk("ovf_hold", bus.oOvf, 0);

        // Randomized traffic with a reset in the middle
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            drive(($urandom % 4) != 0, ($urandom % 16) == 0,
                  int'($urandom), int'($urandom), int'($urandom % 16),
                  ($urandom % 4) != 0);
        end
        idle(10, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
